// File: rtl/instr_encoder_loader.sv
// Assembles MIPS R/I/J words from an op selector plus fields and writes
// them sequentially into instruction memory (IDLE -> WRITE -> IDLE/FULL).
// Ports: clk, reset (async high), clear_i (sync restart), valid_i/ready_o
//   request handshake, op_sel_i/rs_i/rt_i/rd_i/shamt_i/funct_i/imm_i/target_i
//   request fields, imem_we_o/imem_addr_o/imem_wdata_o memory write port,
//   count_o words written, full_o DEPTH written, err_o sticky illegal op.
// Optional: ENCODER_CHECKSUM_EN adds checksum_o, the XOR of committed words.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [3:0]            op_sel_i,
  input  logic [4:0]            rs_i,
  input  logic [4:0]            rt_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            shamt_i,
  input  logic [5:0]            funct_i,
  input  logic [15:0]           imm_i,
  input  logic [25:0]           target_i,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wdata_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  full_o,
  output logic                  err_o
`ifdef ENCODER_CHECKSUM_EN
  ,
  output logic [31:0]           checksum_o
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH:0] DEPTH_C =
    (ADDR_WIDTH+1)'(DEPTH);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH:0]   cnt_inc;
  logic [31:0]           enc;
  logic                  legal;
`ifdef ENCODER_CHECKSUM_EN
  logic [31:0]           cks_q, cks_d;
`endif

  // Combinational encoder for the offered request.
  always_comb begin
    enc   = 32'h0;
    legal = 1'b1;
    unique case (op_sel_i)
      4'b0000: enc = {6'h08, rs_i, rt_i, imm_i};
      4'b0001: enc = {6'h0D, rs_i, rt_i, imm_i};
      4'b0010: enc = {6'h0F, 5'd0, rt_i, imm_i};
      4'b0011: enc = {6'h0C, rs_i, rt_i, imm_i};
      4'b0100: enc = {6'h23, rs_i, rt_i, imm_i};
      4'b0101: enc = {6'h2B, rs_i, rt_i, imm_i};
      4'b0110: enc = {6'h04, rs_i, rt_i, imm_i};
      4'b0111: enc = {6'h05, rs_i, rt_i, imm_i};
      4'b1000: enc = {6'h02, target_i};
      4'b1001: enc = {6'h03, target_i};
      4'b1111: enc = {6'h00, rs_i, rt_i, rd_i,
                      shamt_i, funct_i};
      default: legal = 1'b0;
    endcase
  end

  assign cnt_inc = count_q + 1'b1;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wdata_d = wdata_q;
    err_d   = err_q;
`ifdef ENCODER_CHECKSUM_EN
    cks_d   = cks_q;
`endif
    if (clear_i) begin
      state_d = IDLE;
      addr_d  = '0;
      count_d = '0;
      err_d   = 1'b0;
`ifdef ENCODER_CHECKSUM_EN
      cks_d   = 32'h0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (legal) begin
              wdata_d = enc;
              state_d = WRITE;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        WRITE: begin
          count_d = cnt_inc;
`ifdef ENCODER_CHECKSUM_EN
          cks_d   = cks_q ^ wdata_q;
`endif
          // Address holds at DEPTH-1 once full instead of wrapping.
          if (cnt_inc == DEPTH_C) begin
            state_d = FULL;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = IDLE;
          end
        end
        FULL: state_d = FULL;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      count_q <= '0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
`ifdef ENCODER_CHECKSUM_EN
      cks_q   <= 32'h0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
`ifdef ENCODER_CHECKSUM_EN
      cks_q   <= cks_d;
`endif
    end
  end

  assign ready_o      = (state_q == IDLE);
  // A clear in the WRITE cycle aborts the write combinationally.
  assign imem_we_o    = (state_q == WRITE) && !clear_i;
  assign imem_addr_o  = addr_q;
  assign imem_wdata_o = wdata_q;
  assign count_o      = count_q;
  assign full_o       = (state_q == FULL);
  assign err_o        = err_q;
`ifdef ENCODER_CHECKSUM_EN
  assign checksum_o   = cks_q;
`endif

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Scoreboard bench for instr_encoder_loader.
// Expected writes are queued on accept and popped on imem_we_o.
module tb_instr_encoder_loader;

  localparam int AW = 6;

  logic          clk = 0;
  logic          reset;
  logic          clear_i;
  logic          valid_i;
  logic          ready_o;
  logic [3:0]    op_sel_i;
  logic [4:0]    rs_i, rt_i, rd_i, shamt_i;
  logic [5:0]    funct_i;
  logic [15:0]   imm_i;
  logic [25:0]   target_i;
  logic          imem_we_o;
  logic [AW-1:0] imem_addr_o;
  logic [31:0]   imem_wdata_o;
  logic [AW:0]   count_o;
  logic          full_o;
  logic          err_o;
`ifdef ENCODER_CHECKSUM_EN
  logic [31:0]   checksum_o;
`endif

  instr_encoder_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .clear_i(clear_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .op_sel_i(op_sel_i), .rs_i(rs_i), .rt_i(rt_i),
    .rd_i(rd_i), .shamt_i(shamt_i), .funct_i(funct_i),
    .imm_i(imm_i), .target_i(target_i),
    .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o),
    .imem_wdata_o(imem_wdata_o), .count_o(count_o),
    .full_o(full_o), .err_o(err_o)
`ifdef ENCODER_CHECKSUM_EN
    , .checksum_o(checksum_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [37:0] sb[$];
  logic [AW-1:0] exp_addr = '0;
  logic [31:0] cks_m = 32'h0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we_o) begin
      if (sb.size() == 0) begin
        chk("spurious_we", 1, 0);
      end else begin
        logic [37:0] e;
        e = sb.pop_front();
        chk("addr", 64'(imem_addr_o), 64'(e[37:32]));
        chk("wdata", 64'(imem_wdata_o), 64'(e[31:0]));
        cks_m ^= e[31:0];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    op_sel_i = 4'($urandom);
    rs_i = 5'($urandom); rt_i = 5'($urandom);
    rd_i = 5'($urandom); shamt_i = 5'($urandom);
    funct_i = 6'($urandom); imm_i = 16'($urandom);
    target_i = 26'($urandom);
  endtask

  // Offer one request; push expectation if it should be written.
  task automatic send(input logic [3:0] op,
                      input logic [4:0] rs, rt, rd, sh,
                      input logic [5:0] fn,
                      input logic [15:0] imm,
                      input logic [25:0] tgt,
                      input logic [31:0] w,
                      input bit push);
    int n = 0;
    while (!ready_o && n < 20) begin
      tick(1); n++;
    end
    if (!ready_o) chk("ready_timeout", 0, 1);
    valid_i = 1; op_sel_i = op;
    rs_i = rs; rt_i = rt; rd_i = rd;
    shamt_i = sh; funct_i = fn;
    imm_i = imm; target_i = tgt;
    if (push) begin
      sb.push_back({exp_addr, w});
      exp_addr++;
    end
    tick(1);
    valid_i = 0;
    scramble();
  endtask

  task automatic do_clear();
    clear_i = 1;
    tick(1);
    clear_i = 0;
    exp_addr = '0;
    cks_m = 32'h0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      tick(1); n++;
    end
    chk(tag, 64'(sb.size()), 0);
  endtask

  initial begin
    reset = 1; clear_i = 0; valid_i = 0;
    scramble();
    tick(2);
    reset = 0;
    tick(1);
    chk("rst_ready", 64'(ready_o), 1);
    chk("rst_we", 64'(imem_we_o), 0);
    chk("rst_addr", 64'(imem_addr_o), 0);
    chk("rst_wdata", 64'(imem_wdata_o), 0);
    chk("rst_count", 64'(count_o), 0);
    chk("rst_full", 64'(full_o), 0);
    chk("rst_err", 64'(err_o), 0);

    // addi: write appears the cycle after accept.
    send(4'h0, 0, 8, 0, 0, 0, 16'h0005, 0,
         32'h20080005, 1);
    chk("lat_we", 64'(imem_we_o), 1);
    chk("lat_ready", 64'(ready_o), 0);
    tick(1);
    chk("cnt1", 64'(count_o), 1);

    send(4'hF, 8, 9, 10, 0, 6'h20, 0, 0,
         32'h01095020, 1);
    send(4'h8, 0, 0, 0, 0, 0, 0, 26'h0100000,
         32'h08100000, 1);
    send(4'h2, 7, 1, 0, 0, 0, 16'h1001, 0,
         32'h3C011001, 1);
    send(4'h6, 8, 9, 0, 0, 0, 16'hFFFF, 0,
         32'h1109FFFF, 1);
    send(4'h5, 29, 31, 0, 0, 0, 16'h0010, 0,
         32'hAFBF0010, 1);
    send(4'h9, 0, 0, 0, 0, 0, 0, 26'h3FFFFFF,
         32'h0FFFFFFF, 1);
    drain("drain_mix");
    tick(1);
    chk("cnt7", 64'(count_o), 7);
`ifdef ENCODER_CHECKSUM_EN
    chk("cks_mix", 64'(checksum_o), 64'(cks_m));
`endif

    // Illegal op: dropped, sticky error.
    send(4'hA, 1, 2, 3, 4, 5, 16'h1234, 0, 0, 0);
    tick(2);
    chk("ill_err", 64'(err_o), 1);
    chk("ill_cnt", 64'(count_o), 7);
    chk("ill_addr", 64'(imem_addr_o), 7);
    send(4'h1, 3, 4, 0, 0, 0, 16'hBEEF, 0,
         32'h3464BEEF, 1);
    drain("drain_ori");
    tick(1);
    chk("err_sticky", 64'(err_o), 1);
    do_clear();
    chk("clr_err", 64'(err_o), 0);
    chk("clr_cnt", 64'(count_o), 0);
    chk("clr_addr", 64'(imem_addr_o), 0);
`ifdef ENCODER_CHECKSUM_EN
    chk("clr_cks", 64'(checksum_o), 0);
`endif

    // Fill all 64 words back to back.
    for (int i = 0; i < 64; i++) begin
      logic [15:0] im;
      im = 16'(i * 3 + 1);
      send(4'h0, 5'(i), 5'(i + 1), 0, 0, 0, im, 0,
           {6'h08, 5'(i), 5'(i + 1), im}, 1);
    end
    drain("drain_fill");
    tick(1);
    chk("full", 64'(full_o), 1);
    chk("full_ready", 64'(ready_o), 0);
    chk("full_cnt", 64'(count_o), 64);
    chk("full_addr", 64'(imem_addr_o), 63);
`ifdef ENCODER_CHECKSUM_EN
    chk("cks_full", 64'(checksum_o), 64'(cks_m));
`endif
    valid_i = 1; op_sel_i = 4'h0;
    tick(4);
    valid_i = 0;
    chk("full_hold", 64'(full_o), 1);
    chk("full_cnt2", 64'(count_o), 64);
    do_clear();
    chk("clr_full", 64'(full_o), 0);
    chk("clr_addr2", 64'(imem_addr_o), 0);
    chk("clr_ready", 64'(ready_o), 1);

    // Clear during WRITE aborts the pending write.
    send(4'h0, 0, 8, 0, 0, 0, 16'h0001, 0,
         32'h20080001, 1);
    drain("drain_pre");
    tick(1);
    send(4'h3, 1, 2, 0, 0, 0, 16'h00FF, 0, 0, 0);
    clear_i = 1;
    #1;
    chk("abort_we", 64'(imem_we_o), 0);
    tick(1);
    clear_i = 0;
    exp_addr = '0; cks_m = 32'h0;
    chk("abort_cnt", 64'(count_o), 0);
    chk("abort_addr", 64'(imem_addr_o), 0);
`ifdef ENCODER_CHECKSUM_EN
    chk("abort_cks", 64'(checksum_o), 0);
`endif
    send(4'h4, 29, 8, 0, 0, 0, 16'h0004, 0,
         32'h8FA80004, 1);
    drain("drain_lw");
    tick(1);
    chk("post_cnt", 64'(count_o), 1);
`ifdef ENCODER_CHECKSUM_EN
    chk("cks_post", 64'(checksum_o), 64'(cks_m));
`endif

    // Async reset during WRITE.
    send(4'h7, 1, 2, 0, 0, 0, 16'h0002, 0, 0, 0);
    reset = 1;
    #1;
    chk("rst_async_we", 64'(imem_we_o), 0);
    chk("rst_async_cnt", 64'(count_o), 0);
    tick(1);
    reset = 0;
    exp_addr = '0; cks_m = 32'h0;
    tick(1);
    chk("rst2_ready", 64'(ready_o), 1);
    chk("rst2_wdata", 64'(imem_wdata_o), 0);
`ifdef ENCODER_CHECKSUM_EN
    chk("rst2_cks", 64'(checksum_o), 0);
`endif
    chk("sb_empty", 64'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
